// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned multiplier with a selectable approximate mode: the low
// APPROX_COLS product columns are OR-compressed, the upper columns are summed exactly.

// One partial-product row (a[J] & b, shifted by J), split into the columns
// that are OR-compressed (lo) and the columns that are summed exactly (hi).
module approx_mul_row #(
  parameter int WA = 8,
  parameter int WB = 8,
  parameter int J  = 0,
  parameter int AC = 0
) (
  input  logic             aj,
  input  logic [WB-1:0]    b,
  output logic [WA+WB-1:0] hi,
  output logic [WA+WB-1:0] lo
);
  localparam int W = WA + WB;
  localparam logic [W-1:0] LO_MASK = W'((64'd1 << AC) - 64'd1);

  logic [W-1:0] row;

  assign row = W'(b & {WB{aj}}) << J;
  assign hi  = row & ~LO_MASK;
  assign lo  = row & LO_MASK;
endmodule

module approx_mul_pipe #(
  parameter int WA          = 8,
  parameter int WB          = 8,
  parameter int APPROX_COLS = 12,
  parameter int STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] product,
  output logic             out_mode,
  output logic [15:0]      txn_count
);
  localparam int W  = WA + WB;
  // First stage holding a result: operands get their own register when depth allows.
  localparam int R0 = (STAGES == 1) ? 1 : 2;

  typedef struct packed {
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          mode;
  } op_t;

  typedef struct packed {
    logic [W-1:0] prod;
    logic         mode;
  } res_t;

  logic                 stall;
  logic                 accept;
  logic [STAGES:1]      vld_pipe;
  op_t                  op_c;
  res_t                 res_c;
  res_t [STAGES:R0]     res_pipe;
  logic [WA-1:0][W-1:0] row_hi;
  logic [WA-1:0][W-1:0] row_lo;
  logic [W-1:0]         hi_sum;
  logic [W-1:0]         lo_sum;
  logic [W-1:0]         lo_or;

  assign stall    = vld_pipe[STAGES] && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else if (!stall) begin
      vld_pipe[1] <= accept;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end

  generate
    if (STAGES == 1) begin : g_op_comb
      assign op_c = {a, b, mode};
    end else begin : g_op_reg
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) op_c <= '0;
        else if (!stall) op_c <= {a, b, mode};
    end
  endgenerate

  generate
    for (genvar j = 0; j < WA; j++) begin : g_row
      approx_mul_row #(.WA(WA), .WB(WB), .J(j), .AC(APPROX_COLS)) u_row (
        .aj (op_c.a[j]),
        .b  (op_c.b),
        .hi (row_hi[j]),
        .lo (row_lo[j])
      );
    end
  endgenerate

  // hi_sum has zeros below APPROX_COLS, so OR-ing in the column flags is carry-free.
  always_comb begin
    hi_sum = '0;
    lo_sum = '0;
    lo_or  = '0;
    for (int j = 0; j < WA; j++) begin
      hi_sum = hi_sum + row_hi[j];
      lo_sum = lo_sum + row_lo[j];
      lo_or  = lo_or | row_lo[j];
    end
    res_c.mode = op_c.mode;
    res_c.prod = op_c.mode ? (hi_sum | lo_or) : (hi_sum + lo_sum);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) res_pipe <= '0;
    else if (!stall) begin
      res_pipe[R0] <= res_c;
      for (int s = R0 + 1; s <= STAGES; s++) res_pipe[s] <= res_pipe[s-1];
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) txn_count <= '0;
    else if (out_valid && out_ready && txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;

  assign out_valid = vld_pipe[STAGES];
  assign product   = res_pipe[STAGES].prod;
  assign out_mode  = res_pipe[STAGES].mode;
endmodule

// File: tb/tb_approx_mul_pipe.sv
// Scoreboard bench for approx_mul_pipe (WA=WB=8, APPROX_COLS=12, STAGES=2):
// driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_approx_mul_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        out_mode;
  logic [15:0] txn_count;

  typedef struct {
    logic [15:0] prod;
    logic        mode;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          pops = 0;
  int          stall_seen = 0;
  bit          was_stalled = 0;
  logic [15:0] held_prod;
  logic        held_mode;

  approx_mul_pipe #(.WA(8), .WB(8), .APPROX_COLS(12), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .out_mode  (out_mode),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: result checks on every transfer, hold checks on every stall cycle
  always @(negedge clk) begin
    if (!rst_n) was_stalled = 0;
    else begin
      if (out_valid && out_ready) begin
        ncmp++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL stale_result: got product=%h with nothing outstanding", product);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          pops++;
          if (product !== e.prod || out_mode !== e.mode) begin
            nfail++;
            $display("FAIL result: got %h/%b want %h/%b", product, out_mode, e.prod, e.mode);
          end
          if (e.lat) begin
            ncmp++;
            if (cyc - e.acc != 2) begin
              nfail++;
              $display("FAIL latency: got %0d cycles want 2", cyc - e.acc);
            end
          end
        end
      end
      if (out_valid && !out_ready) begin
        stall_seen++;
        ncmp++;
        if (in_ready !== 1'b0) begin
          nfail++;
          $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        if (was_stalled) begin
          ncmp++;
          if (product !== held_prod || out_mode !== held_mode) begin
            nfail++;
            $display("FAIL stall_hold: got %h/%b want %h/%b", product, out_mode, held_prod, held_mode);
          end
        end
        held_prod   = product;
        held_mode   = out_mode;
        was_stalled = 1;
      end else was_stalled = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // called at posedge+#1; returns at posedge+#1 after the beat is accepted
  task automatic send(input logic [7:0] ta, input logic [7:0] tb2, input logic tm,
                      input logic [15:0] tp, input bit lat);
    bit   ok;
    exp_t e;
    ok = 0;
    a = ta; b = tb2; mode = tm; in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        e.prod = tp; e.mode = tm; e.acc = cyc; e.lat = lat;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      ncmp++; nfail++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles want 1");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_product", product, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_txn_count", txn_count, 0);
    rst_n = 1'b1;

    // exact/approx vectors back to back, latency checked on each
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1);
    send(8'hFF, 8'hFF, 1'b1, 16'hBFFF, 1);
    send(8'h03, 8'h03, 1'b1, 16'h0007, 1);
    send(8'h03, 8'h03, 1'b0, 16'h0009, 1);
    send(8'h12, 8'h34, 1'b0, 16'h03A8, 1);
    send(8'h12, 8'h34, 1'b1, 16'h0368, 1);
    send(8'hF0, 8'h0F, 1'b1, 16'h07F0, 1);
    send(8'hF0, 8'h0F, 1'b0, 16'h0E10, 1);
    send(8'h80, 8'h80, 1'b1, 16'h4000, 1);
    drain();
    chk("txn_after_vectors", txn_count, 9);

    // backpressure: three beats while the consumer stalls for 4 cycles
    out_ready = 1'b0;
    fork
      begin
        send(8'h03, 8'h03, 1'b0, 16'h0009, 0);
        send(8'hFF, 8'hFF, 1'b1, 16'hBFFF, 0);
        send(8'h12, 8'h34, 1'b0, 16'h03A8, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_observed", stall_seen >= 2, 1);
    chk("txn_after_stall", txn_count, 12);

    // reset with two beats in flight
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    send(8'h03, 8'h03, 1'b1, 16'h0007, 0);
    chk("inflight_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_txn_count", txn_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_product", product, 0);
    exp_q.delete();
    pops = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(8'h80, 8'h80, 1'b0, 16'h4000, 1);
    drain();
    chk("txn_after_reset", txn_count, 1);

    // saturation: stream 65540 transfers at full rate
    for (int i = 0; i < 65540; i++) begin
      if (i % 2 == 0) send(8'h03, 8'h03, 1'b1, 16'h0007, 1);
      else            send(8'h03, 8'h03, 1'b0, 16'h0009, 1);
    end
    drain();
    chk("txn_saturated", txn_count, 16'hFFFF);
    chk("txn_vs_model", txn_count, (pops > 65535) ? 65535 : pops);
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1);
    send(8'hFF, 8'hFF, 1'b1, 16'hBFFF, 1);
    drain();
    chk("txn_stays_saturated", txn_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
